// File: rtl/rv32_div_pkg.sv
// Shared types, constants and helpers for the rv32_div divide/remainder unit.
// Optional build macro RV32_DIV_FAST_EN is consumed by rv32_div.sv.

// Fallback M-extension bit indices; the shared RV32 define header, when compiled first, takes precedence.
`ifndef MUL
`define MUL 0
`endif
`ifndef DIV
`define DIV 4
`endif
`ifndef DIVU
`define DIVU 5
`endif
`ifndef REM
`define REM 6
`endif
`ifndef REMU
`define REMU 7
`endif

package rv32_div_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } div_state_e;

    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [4:0]  CNT_LAST = 5'd31;

    localparam logic [7:0] DIV_OP_MASK = (8'b1 << `DIV) | (8'b1 << `DIVU) | (8'b1 << `REM) | (8'b1 << `REMU);
    localparam logic [7:0] SIGNED_MASK = (8'b1 << `DIV) | (8'b1 << `REM);
    localparam logic [7:0] REM_MASK    = (8'b1 << `REM) | (8'b1 << `REMU);

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? neg32(v) : v;
    endfunction

endpackage

// File: rtl/rv32_div_step.sv
// One restoring-division step: shift in the next dividend bit and try to subtract the divisor.

module rv32_div_step
    import rv32_div_pkg::*;
(
    input  logic [31:0] rem,
    input  logic        quo_msb,
    input  logic [31:0] dvs,
    output logic [31:0] rem_next,
    output logic        q_bit
);

    logic [33:0] trial_s;

    // Trial subtraction with headroom so the sign bit is unambiguous for any divisor.
    always_comb begin
        trial_s = {1'b0, rem, quo_msb} - {2'b00, dvs};
        if (!trial_s[33]) begin
            rem_next = trial_s[31:0];
            q_bit    = 1'b1;
        end else begin
            rem_next = {rem[30:0], quo_msb};
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/rv32_div.sv
// Iterative 32-bit DIV/DIVU/REM/REMU unit with a combinational pending stall handshake.
// Build option: RV32_DIV_FAST_EN finishes divide-by-zero and signed overflow in the load cycle.

module rv32_div
    import rv32_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [7:0]  MD_type,
    output logic [31:0] out,
    output logic        pending
);

    div_state_e  state_r, state_s;
    logic [4:0]  cnt_r, cnt_s;
    logic [31:0] rem_r, rem_s;
    logic [31:0] quo_r, quo_s;
    logic [31:0] dvs_r, dvs_s;
    logic        neg_quo_r, neg_quo_s;
    logic        neg_rem_r, neg_rem_s;
    logic        is_rem_r, is_rem_s;

    logic        div_op_s;
    logic        is_signed_s;
    logic        op_is_rem_s;
    logic [31:0] step_rem_s;
    logic        step_bit_s;
    logic [31:0] quo_next_s;
    logic        special_s;
    logic [31:0] special_out_s;

    assign div_op_s    = |(MD_type & DIV_OP_MASK);
    assign is_signed_s = |(MD_type & SIGNED_MASK);
    assign op_is_rem_s = |(MD_type & REM_MASK);

    rv32_div_step u_step (
        .rem      (rem_r),
        .quo_msb  (quo_r[31]),
        .dvs      (dvs_r),
        .rem_next (step_rem_s),
        .q_bit    (step_bit_s)
    );

    assign quo_next_s = {quo_r[30:0], step_bit_s};

`ifdef RV32_DIV_FAST_EN
    // Divide-by-zero and INT_MIN/-1 have closed-form results, so skip the iteration.
    always_comb begin
        if (y == 32'd0) begin
            special_s     = 1'b1;
            special_out_s = op_is_rem_s ? x : ALL_ONES;
        end else if (is_signed_s && (x == INT_MIN) && (y == ALL_ONES)) begin
            special_s     = 1'b1;
            special_out_s = op_is_rem_s ? 32'd0 : INT_MIN;
        end else begin
            special_s     = 1'b0;
            special_out_s = 32'd0;
        end
    end
`else
    assign special_s     = 1'b0;
    assign special_out_s = 32'd0;
`endif

    // Next-state, datapath update and combinational handshake outputs.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        rem_s     = rem_r;
        quo_s     = quo_r;
        dvs_s     = dvs_r;
        neg_quo_s = neg_quo_r;
        neg_rem_s = neg_rem_r;
        is_rem_s  = is_rem_r;
        out       = 32'd0;
        pending   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (div_op_s && special_s) begin
                    out     = special_out_s;
                    pending = 1'b0;
                end else if (div_op_s) begin
                    pending   = 1'b1;
                    state_s   = ST_RUN;
                    cnt_s     = 5'd0;
                    rem_s     = 32'd0;
                    quo_s     = mag32(x, is_signed_s);
                    dvs_s     = mag32(y, is_signed_s);
                    // A zero divisor must yield all-ones regardless of operand signs.
                    neg_quo_s = is_signed_s & (x[31] ^ y[31]) & (y != 32'd0);
                    neg_rem_s = is_signed_s & x[31];
                    is_rem_s  = op_is_rem_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!div_op_s) begin
                    state_s = ST_IDLE;
                end else begin
                    rem_s = step_rem_s;
                    quo_s = quo_next_s;
                    cnt_s = cnt_r + 5'd1;
                    if (cnt_r == CNT_LAST) begin
                        state_s = ST_IDLE;
                        pending = 1'b0;
                        if (is_rem_r) begin
                            out = neg_rem_r ? neg32(step_rem_s) : step_rem_s;
                        end else begin
                            out = neg_quo_r ? neg32(quo_next_s) : quo_next_s;
                        end
                    end else begin
                        pending = 1'b1;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 5'd0;
            rem_r     <= 32'd0;
            quo_r     <= 32'd0;
            dvs_r     <= 32'd0;
            neg_quo_r <= 1'b0;
            neg_rem_r <= 1'b0;
            is_rem_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            rem_r     <= rem_s;
            quo_r     <= quo_s;
            dvs_r     <= dvs_s;
            neg_quo_r <= neg_quo_s;
            neg_rem_r <= neg_rem_s;
            is_rem_r  <= is_rem_s;
        end
    end

endmodule

// File: tb/tb_rv32_div.sv
// Self-checking bench for rv32_div: arithmetic reference model plus directed vectors.
// Honours RV32_DIV_FAST_EN for the expected latency of special cases.

module tb_rv32_div;

    localparam int B_MUL  = 0;
    localparam int B_DIV  = 4;
    localparam int B_DIVU = 5;
    localparam int B_REM  = 6;
    localparam int B_REMU = 7;

    logic        clk;
    logic        rst_n;
    logic [31:0] x;
    logic [31:0] y;
    logic [7:0]  md;
    logic [31:0] out;
    logic        pending;

    logic [31:0] exp_out;
    logic        exp_pend;
    int          n_cmp;
    int          n_bad;

    rv32_div dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .x       (x),
        .y       (y),
        .MD_type (md),
        .out     (out),
        .pending (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] r;
        sa = a;
        sb = b;
        case (op)
            B_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            B_REMU: return (b == 32'd0) ? a : a % b;
            B_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                r = sa / sb;
                return r;
            end
            B_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                r = sa % sb;
                return r;
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit is_special(input int op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) ||
               ((op == B_DIV || op == B_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Single compare process: outputs checked against the expectation for this cycle.
    always @(negedge clk) begin
        n_cmp = n_cmp + 1;
        if (pending !== exp_pend || out !== exp_out) begin
            n_bad = n_bad + 1;
            $display("FAIL cycle_check t=%0t: got pending=%b out=%h, want pending=%b out=%h",
                     $time, pending, out, exp_pend, exp_out);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] lit);
        logic [31:0] r;
        int          lat;
        r = model(op, a, b);
        n_cmp = n_cmp + 1;
        if (r !== lit) begin
            n_bad = n_bad + 1;
            $display("FAIL model_pin op=%0d x=%h y=%h: model=%h, hand value=%h", op, a, b, r, lit);
        end
        lat = 33;
`ifdef RV32_DIV_FAST_EN
        if (is_special(op, a, b)) lat = 1;
`else
        if (is_special(op, a, b)) lat = 33;
`endif
        md = 8'b1 << op;
        x  = a;
        y  = b;
        for (int k = 0; k < lat; k++) begin
            exp_pend = (k != lat - 1);
            exp_out  = (k == lat - 1) ? r : 32'd0;
            next_cycle();
        end
        md       = 8'd0;
        x        = 32'd0;
        y        = 32'd0;
        exp_pend = 1'b0;
        exp_out  = 32'd0;
    endtask

    task automatic partial_op(input int op, input logic [31:0] a, input logic [31:0] b, input int cycles);
        md = 8'b1 << op;
        x  = a;
        y  = b;
        for (int k = 0; k < cycles; k++) begin
            exp_pend = 1'b1;
            exp_out  = 32'd0;
            next_cycle();
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        md       = 8'd0;
        x        = 32'd0;
        y        = 32'd0;
        exp_pend = 1'b0;
        exp_out  = 32'd0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        run_op(B_DIVU, 32'd100, 32'd7, 32'd14);
        run_op(B_REMU, 32'd100, 32'd7, 32'd2);
        run_op(B_DIV,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
        run_op(B_REM,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
        run_op(B_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_op(B_REM,  32'd7, 32'hFFFF_FFFE, 32'd1);
        run_op(B_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op(B_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1);
        run_op(B_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1);
        run_op(B_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);

        run_op(B_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        run_op(B_DIV,  32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        run_op(B_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678);
        run_op(B_REM,  32'h1234_5678, 32'd0, 32'h1234_5678);
        run_op(B_DIV,  32'h8765_4321, 32'd0, 32'hFFFF_FFFF);
        run_op(B_REM,  32'h8765_4321, 32'd0, 32'h8765_4321);
        run_op(B_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op(B_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        md = 8'b1 << B_MUL;
        x  = 32'd5;
        y  = 32'd6;
        for (int k = 0; k < 4; k++) begin
            exp_pend = 1'b0;
            exp_out  = 32'd0;
            next_cycle();
        end
        run_op(B_DIVU, 32'd81, 32'd9, 32'd9);

        partial_op(B_DIVU, 32'd1000, 32'd3, 11);
        rst_n    = 1'b0;
        md       = 8'd0;
        exp_pend = 1'b0;
        exp_out  = 32'd0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        run_op(B_DIVU, 32'd9, 32'd3, 32'd3);

        partial_op(B_DIVU, 32'd50, 32'd5, 6);
        md       = 8'd0;
        exp_pend = 1'b0;
        exp_out  = 32'd0;
        next_cycle();
        run_op(B_REMU, 32'd50, 32'd6, 32'd2);

        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
